// File: rtl/seq_pkg.sv
// Shared definitions for the 1010 frame generator.
//   - 3-bit state encodings (IDLE = 3'b000) and the state enum
//   - DEFAULT_PATTERN: default 4-bit frame pattern, sent MSB first
//   - pattern_bit(): serial bit presented in a given state
// Optional feature macro: SEQ_GEN_GAP_EN adds the GAP state between frames.
package seq_pkg;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_BIT3 = 3'b001;
  localparam logic [2:0] ST_BIT2 = 3'b010;
  localparam logic [2:0] ST_BIT1 = 3'b011;
  localparam logic [2:0] ST_BIT0 = 3'b100;
`ifdef SEQ_GEN_GAP_EN
  localparam logic [2:0] ST_GAP  = 3'b101;
`endif

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    BIT3 = ST_BIT3,
    BIT2 = ST_BIT2,
    BIT1 = ST_BIT1,
    BIT0 = ST_BIT0
`ifdef SEQ_GEN_GAP_EN
    , GAP = ST_GAP
`endif
  } state_t;

  // IDLE and GAP (and any unused code) present a 0 on the line.
  function automatic logic pattern_bit(input state_t st, input logic [3:0] pat);
    case (st)
      BIT3:    return pat[3];
      BIT2:    return pat[2];
      BIT1:    return pat[1];
      BIT0:    return pat[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seq_frame_cnt.sv
// Loadable frame down-counter with zero / last flags.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (clears count to 0)
//   load     in   load load_val (has priority over dec)
//   load_val in   W  value to load
//   dec      in   decrement by one (held at 0, never wraps)
//   zero     out  count == 0
//   last     out  count == 1 (the next decrement ends the transfer)
module seq_frame_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && !zero) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);
  assign last = (cnt_q == W'(1));

endmodule

// File: rtl/seq_gen_1010.sv
// Serial frame generator: on an accepted start, sends `count` copies of the
// 4-bit PATTERN MSB first, one bit per clock, then pulses done.
// Optional feature macro: SEQ_GEN_GAP_EN inserts one idle-bit GAP cycle
// between consecutive frames (not after the last one).
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   transfer request, honoured only in IDLE with count != 0
//   count  in   CNT_W  number of frames, sampled only when start is accepted
//   y      out  registered serial bit stream
//   busy   out  registered, high in every non-IDLE state
//   done   out  registered, one-cycle pulse on return to IDLE after last frame
//
// state | meaning
// IDLE  | waiting for start, y = 0
// BIT3  | sending PATTERN[3]
// BIT2  | sending PATTERN[2]
// BIT1  | sending PATTERN[1]
// BIT0  | sending PATTERN[0], frame counter decremented on exit
// GAP   | one y = 0 cycle between frames (SEQ_GEN_GAP_EN only)
module seq_gen_1010
  import seq_pkg::*;
#(
  parameter logic [3:0] PATTERN = DEFAULT_PATTERN,
  parameter int         CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             y,
  output logic             busy,
  output logic             done
);

  state_t state_q, state_d;
  logic   cnt_load, cnt_dec;
  logic   cnt_zero, cnt_last;

  seq_frame_cnt #(.W(CNT_W)) u_frame_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (count),
    .dec      (cnt_dec),
    .zero     (cnt_zero),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (count != '0)) begin
          state_d  = BIT3;
          cnt_load = 1'b1;
        end
      end
      BIT3: state_d = BIT2;
      BIT2: state_d = BIT1;
      BIT1: state_d = BIT0;
      BIT0: begin
        cnt_dec = 1'b1;
        // zero can only be seen here if the counter was disturbed; treat it
        // as the end of the transfer rather than wrapping to all-ones.
        if (cnt_last || cnt_zero) begin
          state_d = IDLE;
        end else begin
`ifdef SEQ_GEN_GAP_EN
          state_d = GAP;
`else
          state_d = BIT3;
`endif
        end
      end
`ifdef SEQ_GEN_GAP_EN
      GAP: state_d = BIT3;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with
  // the state they describe (Moore behaviour without a decode stage after
  // the flops).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      y       <= pattern_bit(state_d, PATTERN);
      busy    <= (state_d != IDLE);
      done    <= (state_q == BIT0) && (state_d == IDLE);
    end
  end

endmodule
